operand_stack: RTL
==================

Name: operand_stack

Overview:
- LIFO operand stack of the stack-based processor datapath.
- Sits directly upstream of the ALU: presents top-of-stack (TOS) and next-of-stack (NOS) as the ALU operands and accepts the ALU result back.
- One command per cycle. Supports the pop-two/push-result sequence used by ADD/SUB/MUL/DIV in a single cycle.
- Drives the processor-level empty/full flags.

Parameters:
- DATA_W, 8, word width (signed two's complement, but the stack treats data as opaque bits)
- DEPTH, 16, number of entries (power of 2, >= 4)
- IDX_W, $clog2(DEPTH), index width

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset
- op  in  3  command (encodings in package)
- din  in  DATA_W  push/replace data (immediate, RAM value or ALU result)
- tos  out  DATA_W  entry at index; 0 when empty
- nos  out  DATA_W  entry at index-1; 0 when count<2
- index  out  IDX_W  position of TOS; 0 when empty
- count  out  IDX_W+1  number of valid entries, 0..DEPTH
- empty  out  1  count==0
- full  out  1  count==DEPTH
- overflow  out  1  sticky: a push was attempted while full
- underflow  out  1  sticky: a pop/replace was attempted with insufficient entries
- ack  out  1  registered; 1 the cycle after a command that executed, 0 after a NOP or a rejected command

Behaviour:
- Reset (reset==0 at a clk edge):
  - count=0 and all storage cleared to 0.
  - overflow=0, underflow=0, ack=0.
  - Outputs are therefore tos=0, nos=0, index=0, empty=1, full=0.
  - Reset has priority over any op and aborts nothing partial; every op is atomic in one cycle.
- Commands are sampled at the rising edge. Results are visible on tos/nos/count/index and the flags from the same edge, i.e. readable in the following cycle. tos/nos are combinational reads of the registered storage and count.
- OP_NOP: no change.
- OP_PUSH: mem[count]<=din, count+1.
  - Requires count<DEPTH; otherwise no change and overflow<=1.
- OP_POP: count-1.
  - Requires count>=1; otherwise underflow<=1.
  - The popped slot is not cleared.
- OP_REPLACE: mem[count-1]<=din, count unchanged (unary result).
  - Requires count>=1; otherwise underflow<=1.
- OP_BINOP: mem[count-2]<=din, count-1. This is the ALU result written over the two consumed operands.
  - Requires count>=2; otherwise no change and underflow<=1.
  - The operands are the pre-edge TOS/NOS values: the ALU input is combinational from tos/nos, and the write happens at the same edge.
- OP_POP2: count-2.
  - Requires count>=2; otherwise underflow<=1.
- OP_SWAP: exchange mem[count-1] and mem[count-2].
  - Requires count>=2; otherwise underflow<=1.
- Unused encodings (3'b111): treated as NOP, ack=0.
- A rejected command never modifies storage or count.
- overflow/underflow stay set until reset; no other clear.
- Operand order is fixed for the ALU: in1=nos (older), in2=tos (newer).
  - Example: push 8 then push 2, SUB gives 6; DIV 54/27 gives 2.
- No wrap-around of index: count saturates by rejection at 0 and at DEPTH.

Decomposition:
- stack_pkg:
  - op encodings NOP=0, PUSH=1, POP=2, REPLACE=3, BINOP=4, POP2=5, SWAP=6
  - the DATA_W default
  - a function valid_op(op, count) returning the "executes" condition, shared by RTL and bench
- Single module. Storage is a DEPTH x DATA_W register array inside it; no sub-module is needed.

Test Plan:
- Reset then PUSH 4, PUSH 5, BINOP with din=9 -> count=1, index=0, tos=9, nos=0, ack=1, no flags.
- PUSH 0x11 (17), PUSH 0x12 (18), observe tos=18/nos=17, BINOP din=0xFF -> tos=0xFF ($signed -1), count=1.
- Fill with PUSH 1..16 -> full=1, tos=16, index=15. 17th PUSH of 99 -> overflow=1, ack=0, tos still 16, count=16.
- From empty: POP -> underflow=1, count=0. Then PUSH 7 and BINOP -> rejected, tos=7, count=1.
- PUSH 3, PUSH 9, SWAP -> tos=3, nos=9. REPLACE din=0xEE -> tos=0xEE, nos=9, count=2. POP2 -> empty=1, tos=0.
- Sequence with flags set, then assert reset low for one cycle mid-stream with op=PUSH -> count=0, flags cleared, push ignored.

Source files
------------

// File: rtl/operand_stack_pkg.sv
// Shared definitions for the operand stack: command encodings, default sizes,
// and the "command executes" predicate used wherever legality must be decided.
// Pure declarations; no state, no timing.
package operand_stack_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int DEPTH_DEF  = 16;

    typedef enum logic [2:0] {
        OP_NOP     = 3'd0,
        OP_PUSH    = 3'd1,
        OP_POP     = 3'd2,
        OP_REPLACE = 3'd3,
        OP_BINOP   = 3'd4,
        OP_POP2    = 3'd5,
        OP_SWAP    = 3'd6,
        OP_RSVD    = 3'd7
    } op_t;

    // True when the command is legal for the current occupancy and will execute.
    // NOP and the reserved encoding never "execute" (they produce no ack).
    function automatic logic valid_op(input op_t op, input int unsigned count,
                                      input int unsigned depth);
        case (op)
            OP_PUSH:                    return count < depth;
            OP_POP, OP_REPLACE:         return count >= 1;
            OP_BINOP, OP_POP2, OP_SWAP: return count >= 2;
            default:                    return 1'b0;
        endcase
    endfunction

    // Commands that consume stack entries; a rejected one raises underflow.
    function automatic logic needs_operands(input op_t op);
        case (op)
            OP_POP, OP_REPLACE, OP_BINOP, OP_POP2, OP_SWAP: return 1'b1;
            default:                                        return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/operand_stack_if.sv
// Command/result bundle between the datapath controller and the operand stack.
// Command fields are sampled at the clock edge; results are readable the cycle after.
// No backpressure: every command completes (or is rejected) in one cycle.
interface operand_stack_if #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int IDX_W  = $clog2(DEPTH)
);
    logic [2:0]        op;
    logic [DATA_W-1:0] din;
    logic [DATA_W-1:0] tos;
    logic [DATA_W-1:0] nos;
    logic [IDX_W-1:0]  index;
    logic [IDX_W:0]    count;
    logic              empty;
    logic              full;
    logic              overflow;
    logic              underflow;
    logic              ack;

    modport master (
        output op, din,
        input  tos, nos, index, count, empty, full, overflow, underflow, ack
    );

    modport slave (
        input  op, din,
        output tos, nos, index, count, empty, full, overflow, underflow, ack
    );
endinterface

// File: rtl/operand_stack.sv
// LIFO operand stack feeding the ALU (in1=nos, in2=tos) and taking its result back.
// Latency: one command per cycle, results visible the cycle after the sampling edge.
// No backpressure: illegal commands are dropped and flagged via sticky overflow/underflow.
module operand_stack
    import operand_stack_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int IDX_W  = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            reset,
    operand_stack_if.slave  bus
);

    localparam logic [IDX_W:0]   CNT_ONE  = (IDX_W+1)'(1);
    localparam logic [IDX_W:0]   CNT_TWO  = (IDX_W+1)'(2);
    localparam logic [IDX_W:0]   CNT_FULL = (IDX_W+1)'(DEPTH);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [IDX_W-1:0] IDX_TWO  = IDX_W'(2);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [IDX_W:0]    cnt;
    logic              ovf_q;
    logic              unf_q;
    logic              ack_q;

    op_t               op;
    logic              exec;
    logic [IDX_W-1:0]  push_i;
    logic [IDX_W-1:0]  top_i;
    logic [IDX_W-1:0]  nos_i;

    // Slot arithmetic is modulo DEPTH on the low count bits; at count==DEPTH the
    // low bits are 0, so top_i = DEPTH-1 still lands on the right entry.
    assign op     = op_t'(bus.op);
    assign exec   = valid_op(op, 32'(cnt), DEPTH);
    assign push_i = cnt[IDX_W-1:0];
    assign top_i  = cnt[IDX_W-1:0] - IDX_ONE;
    assign nos_i  = cnt[IDX_W-1:0] - IDX_TWO;

    // Execute one command per edge; rejected commands only touch the sticky flags.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            cnt   <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
            ack_q <= 1'b0;
        end else begin
            ack_q <= exec;
            if (op == OP_PUSH && !exec) begin
                ovf_q <= 1'b1;
            end
            if (needs_operands(op) && !exec) begin
                unf_q <= 1'b1;
            end
            if (exec) begin
                case (op)
                    OP_PUSH: begin
                        mem[push_i] <= bus.din;
                        cnt         <= cnt + CNT_ONE;
                    end
                    OP_POP: begin
                        cnt <= cnt - CNT_ONE;
                    end
                    OP_REPLACE: begin
                        mem[top_i] <= bus.din;
                    end
                    // ALU result overwrites NOS; the old TOS slot becomes free.
                    OP_BINOP: begin
                        mem[nos_i] <= bus.din;
                        cnt        <= cnt - CNT_ONE;
                    end
                    OP_POP2: begin
                        cnt <= cnt - CNT_TWO;
                    end
                    OP_SWAP: begin
                        mem[top_i] <= mem[nos_i];
                        mem[nos_i] <= mem[top_i];
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    // Operand reads are combinational off registered storage so the ALU sees
    // them in the same cycle the BINOP is issued.
    always_comb begin
        bus.tos   = (cnt != '0)      ? mem[top_i] : '0;
        bus.nos   = (cnt >= CNT_TWO) ? mem[nos_i] : '0;
        bus.index = (cnt != '0)      ? top_i      : '0;
    end

    assign bus.count     = cnt;
    assign bus.empty     = (cnt == '0);
    assign bus.full      = (cnt == CNT_FULL);
    assign bus.overflow  = ovf_q;
    assign bus.underflow = unf_q;
    assign bus.ack       = ack_q;

endmodule
